// File: rtl/instr_exec_sequencer.sv
// ============================================================================
// instr_exec_sequencer
// ----------------------------------------------------------------------------
// Purpose:
//   Walks a contiguous (optionally wrapping) window of the 32-entry
//   instruction register. For each entry it fetches opc/op_a/op_b, executes
//   the operation as 64-bit signed arithmetic and writes the result back to
//   the same entry's result field. The host side starts and aborts runs.
//
// Parameters:
//   MULT_LAT  cycles spent in EXEC for MULT (>= 1)
//   DIV_LAT   cycles spent in EXEC for DIV and MOD (>= 1)
//
// Ports:
//   clk         in   1   rising-edge clock
//   reset       in   1   synchronous active-high reset
//   start       in   1   begin a run (only honoured in IDLE)
//   abort       in   1   stop the current run immediately
//   first_addr  in   5   first entry of the window
//   last_addr   in   5   last entry of the window (inclusive, may wrap)
//   busy        out  1   high whenever the sequencer is not IDLE
//   done        out  1   one-cycle pulse at the end of a completed run
//   rd_addr     out  5   read address into the instruction register
//   rd_opc      in   4   opcode, valid one cycle after rd_addr
//   rd_op_a     in   32  signed operand A, same timing as rd_opc
//   rd_op_b     in   32  signed operand B, same timing as rd_opc
//   wb_en       out  1   write-back strobe, one cycle per instruction
//   wb_addr     out  5   write-back address
//   wb_res      out  64  write-back result
//   illegal_op  out  1   sticky flag: an opcode 8..15 ran in this run
//   exec_count  out  6   write-backs completed in the current/last run
//   div0_trap   out  1   (only with INSTR_SEQ_DIV0_TRAP_EN) DIV/MOD by zero
//                        stopped the run
//
// Configuration macro:
//   INSTR_SEQ_DIV0_TRAP_EN - when defined, a DIV/MOD with op_b == 0 writes a
//   zero result, raises div0_trap and ends the run early. When undefined a
//   divide by zero simply writes zero and the run continues.
// ============================================================================
module instr_exec_sequencer #(
   parameter int unsigned MULT_LAT = 2,
   parameter int unsigned DIV_LAT  = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic        [4:0]  first_addr,
   input  logic        [4:0]  last_addr,
   output logic               busy,
   output logic               done,
   output logic        [4:0]  rd_addr,
   input  logic        [3:0]  rd_opc,
   input  logic signed [31:0] rd_op_a,
   input  logic signed [31:0] rd_op_b,
   output logic               wb_en,
   output logic        [4:0]  wb_addr,
   output logic signed [63:0] wb_res,
   output logic               illegal_op,
   output logic        [5:0]  exec_count
`ifdef INSTR_SEQ_DIV0_TRAP_EN
   ,
   output logic               div0_trap
`endif
);

   // Opcode encodings of the instruction register; 8..15 are illegal.
   localparam logic [3:0] OpZero  = 4'd0;
   localparam logic [3:0] OpPassA = 4'd1;
   localparam logic [3:0] OpPassB = 4'd2;
   localparam logic [3:0] OpAdd   = 4'd3;
   localparam logic [3:0] OpSub   = 4'd4;
   localparam logic [3:0] OpMult  = 4'd5;
   localparam logic [3:0] OpDiv   = 4'd6;
   localparam logic [3:0] OpMod   = 4'd7;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      EXEC,
      WB,
      DONE
   } state_t;

   state_t             state_q, state_d;

   logic        [4:0]  ptr_q;
   logic        [4:0]  last_q;
   logic        [15:0] cnt_q;
   logic        [3:0]  opc_q;
   logic signed [31:0] opA_q;
   logic signed [31:0] opB_q;
   logic signed [63:0] res_q;
   logic               illegal_q;
   logic        [5:0]  count_q;

   logic               firstExec;
   logic        [3:0]  effOpc;
   logic signed [31:0] effA;
   logic signed [31:0] effB;
   logic signed [63:0] aExt;
   logic signed [63:0] bExt;
   logic signed [63:0] result;
   logic        [15:0] lat;
   logic               execLast;
   logic               atLast;
   logic               stopEarly;

`ifdef INSTR_SEQ_DIV0_TRAP_EN
   logic               isDiv0;
   logic               trapPend_q;
   logic               div0Trap_q;
`endif

   // The register file answers one cycle after rd_addr, so on the first EXEC
   // cycle the operands come straight from the read port; later EXEC cycles
   // of multi-cycle ops use the copy latched on that first cycle.
   assign firstExec = (cnt_q == 16'd0);
   assign effOpc    = firstExec ? rd_opc  : opc_q;
   assign effA      = firstExec ? rd_op_a : opA_q;
   assign effB      = firstExec ? rd_op_b : opB_q;

   assign aExt = {{32{effA[31]}}, effA};
   assign bExt = {{32{effB[31]}}, effB};

   // Number of cycles the current opcode stays in EXEC.
   always_comb begin
      lat = 16'd1;
      case (effOpc)
         OpMult:        lat = 16'(MULT_LAT);
         OpDiv, OpMod:  lat = 16'(DIV_LAT);
         default:       lat = 16'd1;
      endcase
   end

   assign execLast = (state_q == EXEC) && (cnt_q == (lat - 16'd1));
   assign atLast   = (ptr_q == last_q);

   // Result of the instruction. Operands are sign-extended to 64 bits so
   // add/sub/mult cannot overflow and -2^31 / -1 yields +2^31. SystemVerilog
   // signed division truncates toward zero and the remainder follows the
   // sign of the dividend. Division by zero and illegal opcodes yield zero.
   always_comb begin
      result = 64'sd0;
      case (effOpc)
         OpZero:  result = 64'sd0;
         OpPassA: result = aExt;
         OpPassB: result = bExt;
         OpAdd:   result = aExt + bExt;
         OpSub:   result = aExt - bExt;
         OpMult:  result = aExt * bExt;
         OpDiv:   result = (bExt == 64'sd0) ? 64'sd0 : (aExt / bExt);
         OpMod:   result = (bExt == 64'sd0) ? 64'sd0 : (aExt % bExt);
         default: result = 64'sd0;
      endcase
   end

`ifdef INSTR_SEQ_DIV0_TRAP_EN
   assign isDiv0    = ((effOpc == OpDiv) || (effOpc == OpMod)) && (effB == 32'sd0);
   assign stopEarly = trapPend_q;
`else
   assign stopEarly = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. abort overrides every other transition once a run
   // is in progress, including the WB step.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = FETCH;
         FETCH:   state_d = EXEC;
         EXEC:    if (execLast) state_d = WB;
         WB:      state_d = (atLast || stopEarly) ? DONE : FETCH;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
      end
   end

   // Moore outputs, with abort suppressing the write-back and done pulse of
   // the cycle it arrives in.
   always_comb begin
      busy  = (state_q != IDLE);
      done  = (state_q == DONE) && !abort;
      wb_en = (state_q == WB) && !abort;
   end

   // Datapath: window pointer, EXEC cycle counter, operand latches, result
   // register and run statistics.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q      <= 5'd0;
         last_q     <= 5'd0;
         cnt_q      <= 16'd0;
         opc_q      <= 4'd0;
         opA_q      <= 32'sd0;
         opB_q      <= 32'sd0;
         res_q      <= 64'sd0;
         illegal_q  <= 1'b0;
         count_q    <= 6'd0;
`ifdef INSTR_SEQ_DIV0_TRAP_EN
         trapPend_q <= 1'b0;
         div0Trap_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  ptr_q     <= first_addr;
                  last_q    <= last_addr;
                  illegal_q <= 1'b0;
                  count_q   <= 6'd0;
`ifdef INSTR_SEQ_DIV0_TRAP_EN
                  trapPend_q <= 1'b0;
                  div0Trap_q <= 1'b0;
`endif
               end
            end
            FETCH: begin
               cnt_q <= 16'd0;
            end
            EXEC: begin
               if (!abort) begin
                  if (firstExec) begin
                     opc_q <= rd_opc;
                     opA_q <= rd_op_a;
                     opB_q <= rd_op_b;
                  end
                  if (execLast) begin
                     cnt_q <= 16'd0;
                     res_q <= result;
                     if (effOpc[3]) begin
                        illegal_q <= 1'b1;
                     end
`ifdef INSTR_SEQ_DIV0_TRAP_EN
                     trapPend_q <= isDiv0;
`endif
                  end else begin
                     cnt_q <= cnt_q + 16'd1;
                  end
               end
            end
            WB: begin
               if (!abort) begin
                  count_q <= count_q + 6'd1;
                  if (!atLast && !stopEarly) begin
                     ptr_q <= ptr_q + 5'd1;
                  end
`ifdef INSTR_SEQ_DIV0_TRAP_EN
                  if (trapPend_q) begin
                     div0Trap_q <= 1'b1;
                  end
`endif
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign rd_addr    = ptr_q;
   assign wb_addr    = ptr_q;
   assign wb_res     = res_q;
   assign illegal_op = illegal_q;
   assign exec_count = count_q;
`ifdef INSTR_SEQ_DIV0_TRAP_EN
   assign div0_trap  = div0Trap_q;
`endif

endmodule

// File: tb/tb_instr_exec_sequencer.sv
// ============================================================================
// tb_instr_exec_sequencer
// ----------------------------------------------------------------------------
// Self-checking bench for instr_exec_sequencer. A behavioural model of the
// 32-entry instruction register feeds the read port; a reference model
// computes, per run, the ordered list of write-backs, their cycle offsets,
// and the final flags. Directed scenarios are followed by random runs.
// ============================================================================
module tb_instr_exec_sequencer;

   localparam int MultLat = 2;
   localparam int DivLat  = 4;
`ifdef INSTR_SEQ_DIV0_TRAP_EN
   localparam bit TrapEn = 1'b1;
`else
   localparam bit TrapEn = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic               abort;
   logic        [4:0]  firstAddr;
   logic        [4:0]  lastAddr;
   logic               busy;
   logic               done;
   logic        [4:0]  rdAddr;
   logic        [3:0]  rdOpc;
   logic signed [31:0] rdOpA;
   logic signed [31:0] rdOpB;
   logic               wbEn;
   logic        [4:0]  wbAddr;
   logic        [63:0] wbRes;
   logic               illegalOp;
   logic        [5:0]  execCount;
`ifdef INSTR_SEQ_DIV0_TRAP_EN
   logic               div0Trap;
`endif

   logic [3:0]  memOpc [32];
   logic [31:0] memA   [32];
   logic [31:0] memB   [32];

   int testsRun    = 0;
   int testsFailed = 0;
   int cycleCnt    = 0;
   int startCyc    = 0;
   int doneCount   = 0;
   int doneCyc     = 0;

   int     obsAddr [$];
   longint obsRes  [$];
   int     obsCyc  [$];
   int     expAddr [$];
   longint expRes  [$];
   int     expCyc  [$];
   bit     expIll;
   bit     expTrap;
   int     expDoneCyc;

   instr_exec_sequencer #(
      .MULT_LAT (MultLat),
      .DIV_LAT  (DivLat)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .first_addr (firstAddr),
      .last_addr  (lastAddr),
      .busy       (busy),
      .done       (done),
      .rd_addr    (rdAddr),
      .rd_opc     (rdOpc),
      .rd_op_a    (rdOpA),
      .rd_op_b    (rdOpB),
      .wb_en      (wbEn),
      .wb_addr    (wbAddr),
      .wb_res     (wbRes),
      .illegal_op (illegalOp),
      .exec_count (execCount)
`ifdef INSTR_SEQ_DIV0_TRAP_EN
      ,
      .div0_trap  (div0Trap)
`endif
   );

   always #5 clk = ~clk;

   // Instruction register model: registered read, data one cycle after address.
   always @(posedge clk) begin
      rdOpc <= memOpc[rdAddr];
      rdOpA <= memA[rdAddr];
      rdOpB <= memB[rdAddr];
   end

   // Monitor: cycle numbering relative to the accepted start, write-back log
   // and done pulses, all sampled on the falling edge.
   always @(negedge clk) begin
      cycleCnt <= cycleCnt + 1;
      if (wbEn) begin
         obsAddr.push_back(int'(wbAddr));
         obsRes.push_back(longint'(wbRes));
         obsCyc.push_back(cycleCnt + 1 - startCyc);
      end
      if (done) begin
         doneCount <= doneCount + 1;
         doneCyc   <= cycleCnt + 1 - startCyc;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   function automatic int opLat(input logic [3:0] opc);
      case (opc)
         4'd5:       return MultLat;
         4'd6, 4'd7: return DivLat;
         default:    return 1;
      endcase
   endfunction

   // Reference arithmetic: division done on magnitudes with the sign applied
   // afterwards, so it does not lean on the simulator's signed operators.
   function automatic longint refRes(input logic [3:0] opc, input logic [31:0] a,
                                     input logic [31:0] b);
      longint sa, sb, ma, mb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      case (opc)
         4'd0: return 0;
         4'd1: return sa;
         4'd2: return sb;
         4'd3: return sa + sb;
         4'd4: return sa - sb;
         4'd5: return sa * sb;
         4'd6: begin
            if (sb == 0) return 0;
            return ((sa < 0) != (sb < 0)) ? -(ma / mb) : (ma / mb);
         end
         4'd7: begin
            if (sb == 0) return 0;
            return (sa < 0) ? -(ma % mb) : (ma % mb);
         end
         default: return 0;
      endcase
   endfunction

   // Expected outcome of a run over first..last from the current memory image.
   task automatic buildModel(input int first, input int last);
      int ptr;
      int cyc;
      ptr = first;
      cyc = 0;
      expAddr.delete();
      expRes.delete();
      expCyc.delete();
      expIll  = 1'b0;
      expTrap = 1'b0;
      for (int n = 0; n < 32; n++) begin
         cyc += 2 + opLat(memOpc[ptr]);
         expAddr.push_back(ptr);
         expRes.push_back(refRes(memOpc[ptr], memA[ptr], memB[ptr]));
         expCyc.push_back(cyc);
         if (memOpc[ptr] >= 4'd8) expIll = 1'b1;
         if (TrapEn && (memOpc[ptr] == 4'd6 || memOpc[ptr] == 4'd7) && memB[ptr] == 32'd0) begin
            expTrap = 1'b1;
            break;
         end
         if (ptr == last) break;
         ptr = (ptr + 1) % 32;
      end
      expDoneCyc = cyc + 1;
   endtask

   task automatic setEntry(input int addr, input logic [3:0] opc, input logic [31:0] a,
                           input logic [31:0] b);
      memOpc[addr] = opc;
      memA[addr]   = a;
      memB[addr]   = b;
   endtask

   function automatic logic [31:0] randOperand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Pulse start with the given window, leaves the bench in cycle 1 of the run.
   task automatic launch(input int first, input int last);
      obsAddr.delete();
      obsRes.delete();
      obsCyc.delete();
      @(posedge clk); #1;
      firstAddr = 5'(first);
      lastAddr  = 5'(last);
      start     = 1'b1;
      @(posedge clk); #1;
      startCyc  = cycleCnt;
      start     = 1'b0;
      firstAddr = 5'($urandom);
      lastAddr  = 5'($urandom);
   endtask

   // Full run against the model: ordering, addresses, results, timing, flags.
   task automatic applyStimulus(input int first, input int last, input bit pokeStart);
      int doneBase;
      int waited;
      buildModel(first, last);
      doneBase = doneCount;
      launch(first, last);
      if (pokeStart) begin
         repeat (2) @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      waited = 0;
      while (doneCount == doneBase && waited < 2000) begin
         @(posedge clk);
         waited++;
      end
      checkOutput("doneTimeout", 64'(waited < 2000), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("donePulses", 64'(doneCount - doneBase), 64'd1);
      checkOutput("doneCycle", 64'(doneCyc), 64'(expDoneCyc));
      checkOutput("wbCount", 64'(obsAddr.size()), 64'(expAddr.size()));
      for (int i = 0; i < expAddr.size() && i < obsAddr.size(); i++) begin
         checkOutput($sformatf("wbAddr[%0d]", i), 64'(obsAddr[i]), 64'(expAddr[i]));
         checkOutput($sformatf("wbRes[%0d]", i), obsRes[i], expRes[i]);
         checkOutput($sformatf("wbCyc[%0d]", i), 64'(obsCyc[i]), 64'(expCyc[i]));
      end
      checkOutput("execCount", 64'(execCount), 64'(expAddr.size()));
      checkOutput("illegalOp", 64'(illegalOp), 64'(expIll));
      checkOutput("busyAfter", 64'(busy), 64'd0);
`ifdef INSTR_SEQ_DIV0_TRAP_EN
      checkOutput("div0Trap", 64'(div0Trap), 64'(expTrap));
`endif
   endtask

   initial begin
      int doneBase;
      for (int i = 0; i < 32; i++) setEntry(i, 4'd0, 32'd0, 32'd0);
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      firstAddr = 5'd0;
      lastAddr  = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstBusy", 64'(busy), 64'd0);
      checkOutput("rstDone", 64'(done), 64'd0);
      checkOutput("rstWbEn", 64'(wbEn), 64'd0);
      checkOutput("rstRdAddr", 64'(rdAddr), 64'd0);
      checkOutput("rstWbAddr", 64'(wbAddr), 64'd0);
      checkOutput("rstWbRes", wbRes, 64'd0);
      checkOutput("rstIllegal", 64'(illegalOp), 64'd0);
      checkOutput("rstExecCnt", 64'(execCount), 64'd0);
      reset = 1'b0;

      // ADD/SUB/PASSB window 0..2
      setEntry(0, 4'd3, 32'd5, -32'sd3);
      setEntry(1, 4'd4, 32'd5, 32'd7);
      setEntry(2, 4'd2, 32'd0, -32'sd9);
      applyStimulus(0, 2, 1'b0);
      checkOutput("basicRes0", obsRes[0], 64'sd2);
      checkOutput("basicRes1", obsRes[1], -64'sd2);
      checkOutput("basicRes2", obsRes[2], -64'sd9);

      // Widest MULT: WB lands on cycle 4 of the run
      setEntry(7, 4'd5, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      applyStimulus(7, 7, 1'b0);
      checkOutput("multRes", obsRes[0], 64'h3FFF_FFFF_0000_0001);
      checkOutput("multCyc", 64'(obsCyc[0]), 64'd4);

      // Signed DIV/MOD corner cases
      setEntry(10, 4'd6, -32'sd7, 32'd2);
      setEntry(11, 4'd7, -32'sd7, 32'd2);
      setEntry(12, 4'd6, 32'h8000_0000, 32'hFFFF_FFFF);
      applyStimulus(10, 12, 1'b0);
      checkOutput("divNeg", obsRes[0], -64'sd3);
      checkOutput("modNeg", obsRes[1], -64'sd1);
      checkOutput("divMinByM1", obsRes[2], 64'h0000_0000_8000_0000);

      // Wrapping window 30..1
      setEntry(30, 4'd1, 32'd30, 32'd0);
      setEntry(31, 4'd1, 32'd31, 32'd0);
      setEntry(0, 4'd1, 32'd100, 32'd0);
      setEntry(1, 4'd1, 32'd101, 32'd0);
      applyStimulus(30, 1, 1'b0);
      checkOutput("wrapAddr1", 64'(obsAddr[1]), 64'd31);
      checkOutput("wrapAddr2", 64'(obsAddr[2]), 64'd0);
      checkOutput("wrapCount", 64'(execCount), 64'd4);

      // Divide by zero at the head of window 3..5
      setEntry(3, 4'd6, 32'd9, 32'd0);
      setEntry(4, 4'd3, 32'd1, 32'd1);
      setEntry(5, 4'd3, 32'd2, 32'd2);
      applyStimulus(3, 5, 1'b0);
      checkOutput("div0Res", obsRes[0], 64'd0);
`ifdef INSTR_SEQ_DIV0_TRAP_EN
      checkOutput("div0Wbs", 64'(obsAddr.size()), 64'd1);
`else
      checkOutput("div0Wbs", 64'(obsAddr.size()), 64'd3);
`endif

      // Illegal opcode with a stray start (and new window) mid-run
      setEntry(20, 4'd3, 32'd4, 32'd4);
      setEntry(21, 4'hC, 32'd4, 32'd4);
      setEntry(22, 4'd4, 32'd4, 32'd1);
      applyStimulus(20, 22, 1'b1);
      checkOutput("illegalRes", obsRes[1], 64'd0);
      checkOutput("illegalFlag", 64'(illegalOp), 64'd1);
      checkOutput("pokeFirst", 64'(obsAddr[0]), 64'd20);

      // Abort during the DIV EXEC of the second entry
      setEntry(0, 4'd3, 32'd1, 32'd1);
      setEntry(1, 4'd6, 32'd100, 32'd7);
      doneBase = doneCount;
      launch(0, 1);
      repeat (5) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      checkOutput("abortBusy", 64'(busy), 64'd0);
      repeat (6) @(posedge clk);
      #1;
      checkOutput("abortWbs", 64'(obsAddr.size()), 64'd1);
      checkOutput("abortAddr", 64'(obsAddr[0]), 64'd0);
      checkOutput("abortDone", 64'(doneCount - doneBase), 64'd0);
      checkOutput("abortCount", 64'(execCount), 64'd1);

      // Abort coinciding with WB suppresses that write-back
      doneBase = doneCount;
      launch(0, 0);
      repeat (2) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("abortWbWbs", 64'(obsAddr.size()), 64'd0);
      checkOutput("abortWbCount", 64'(execCount), 64'd0);
      checkOutput("abortWbDone", 64'(doneCount - doneBase), 64'd0);

      // Full 32-entry window 5..4
      for (int i = 0; i < 32; i++) setEntry(i, 4'($urandom_range(0, 5)), randOperand(), randOperand());
      applyStimulus(5, 4, 1'b0);
      checkOutput("fullCount", 64'(execCount), 64'd32);

      // Reset in the middle of a run
      for (int i = 0; i < 4; i++) setEntry(i, 4'd3, 32'd3, 32'd4);
      doneBase = doneCount;
      launch(0, 3);
      #0 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checkOutput("midRstBusy", 64'(busy), 64'd0);
      checkOutput("midRstWbRes", wbRes, 64'd0);
      checkOutput("midRstExecCnt", 64'(execCount), 64'd0);
      checkOutput("midRstRdAddr", 64'(rdAddr), 64'd0);
      repeat (8) @(posedge clk);
      #1;
      checkOutput("midRstWbs", 64'(obsAddr.size()), 64'd0);
      checkOutput("midRstDone", 64'(doneCount - doneBase), 64'd0);

      // Random programs and windows
      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < 32; i++) begin
            if ($urandom_range(0, 5) == 0) memOpc[i] = 4'($urandom_range(8, 15));
            else memOpc[i] = 4'($urandom_range(0, 7));
            memA[i] = randOperand();
            memB[i] = randOperand();
         end
         applyStimulus(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
